// File: rtl/capture_fifo_port_pkg.sv
// Purpose: shared port map, CONTROL/STATUS bit positions and entry layout for the capture port.
// Latency: n/a (constants and types only).
// Backpressure: n/a. Firmware port/bit constants mirror this package.
package capture_fifo_port_pkg;

  // Port offsets relative to BASE (reads)
  localparam logic [2:0] OFS_STATUS  = 3'd0;
  localparam logic [2:0] OFS_ADDR_LO = 3'd1;
  localparam logic [2:0] OFS_ADDR_HI = 3'd2;
  localparam logic [2:0] OFS_DATA    = 3'd3;
  localparam logic [2:0] OFS_FLAGS   = 3'd4;
  localparam logic [2:0] OFS_THRESH  = 3'd5;
  // Port offsets relative to BASE (writes)
  localparam logic [2:0] OFS_CONTROL = 3'd0;

  // CONTROL bit positions
  localparam int CTRL_EN_BIT      = 0;
  localparam int CTRL_FLUSH_BIT   = 1;
  localparam int CTRL_CLR_OVF_BIT = 2;
  localparam int CTRL_IRQ_EN_BIT  = 3;

  // STATUS bit positions (count occupies bits 4:0)
  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_FULL_BIT  = 6;
  localparam int STAT_EMPTY_BIT = 5;

  // One captured bus sample: {RW, ADDR, DATA}, 25 bits
  typedef struct packed {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

endpackage

// File: rtl/capture_fifo_port_if.sv
// Purpose: groups the sampler push bus and the pBlazeZH I/O bus of the capture port.
// Latency: n/a (wires only).
// Backpressure: none; sampler pushes are fire-and-forget, the CPU bus is strobe based.
// Ports: SAMPLE_* from the bus sampler; PORT_ID/OUT_PORT/strobes/ACK from the CPU;
//        IN_PORT and INTERRUPT back to the CPU.
interface capture_fifo_port_if;
  logic        SAMPLE_VALID;
  logic [15:0] SAMPLE_ADDR;
  logic [7:0]  SAMPLE_DATA;
  logic        SAMPLE_RW;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        READ_STROBE;
  logic        WRITE_STROBE;
  logic        INTERRUPT_ACK;
  logic [7:0]  IN_PORT;
  logic        INTERRUPT;

  modport master (
    output SAMPLE_VALID, SAMPLE_ADDR, SAMPLE_DATA, SAMPLE_RW,
    output PORT_ID, OUT_PORT, READ_STROBE, WRITE_STROBE, INTERRUPT_ACK,
    input  IN_PORT, INTERRUPT
  );

  modport slave (
    input  SAMPLE_VALID, SAMPLE_ADDR, SAMPLE_DATA, SAMPLE_RW,
    input  PORT_ID, OUT_PORT, READ_STROBE, WRITE_STROBE, INTERRUPT_ACK,
    output IN_PORT, INTERRUPT
  );
endinterface

// File: rtl/capture_fifo.sv
// Purpose: synchronous 25-bit FIFO, 2^DEPTH_LOG2 entries, with flush.
// Latency: push visible in count/head on the next cycle; head is combinational from storage.
// Backpressure: push while full is dropped unless a pop commits in the same cycle.
// Ports: clk/rst_n; i_push/i_pop/i_flush/i_dat in; o_head/o_count/o_full/o_empty out.
module capture_fifo
  import capture_fifo_port_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic                i_flush,
  input  entry_t              i_dat,
  output entry_t              o_head,
  output logic [DEPTH_LOG2:0] o_count,
  output logic                o_full,
  output logic                o_empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  entry_t                r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign o_full  = r_count[DEPTH_LOG2];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop on empty is a no-op; a committed pop frees a slot for a same-cycle push
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end
endmodule

// File: rtl/capture_fifo_port.sv
// Purpose: port-mapped capture buffer on the pBlazeZH I/O bus (decode, control, IN_PORT, irq).
// Latency: IN_PORT registered 1 cycle after PORT_ID; INTERRUPT 1 cycle after the irq condition rises.
// Backpressure: none to the sampler; samples arriving while full are dropped and flag overflow.
// Ports: CLK, RESET_N (async, active-low); bus = capture_fifo_port_if.slave.
module capture_fifo_port
  import capture_fifo_port_pkg::*;
#(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [7:0] BASE       = 8'h00
) (
  input logic                CLK,
  input logic                RESET_N,
  capture_fifo_port_if.slave bus
);
  logic                w_sel;
  logic [2:0]          w_ofs;
  logic                w_ctrl_wr;
  logic                w_thr_wr;
  logic                w_flush;
  logic                w_clr_ovf;
  logic                w_push_req;
  logic                w_pop_req;
  logic                w_ovf_evt;
  logic                w_irq_cond;
  logic                w_irq_clr;
  logic [7:0]          w_status;
  logic [7:0]          w_rd_dat;
  entry_t              w_sample;
  entry_t              w_head;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_full;
  logic                w_empty;

  logic [7:0] r_in_port;
  logic       r_enable;
  logic       r_irq_en;
  logic [7:0] r_thresh;
  logic       r_ovf;
  logic       r_irq_cond_q;
  logic       r_irq_pending;

  // BASE is 8-aligned, so the window is selected by the upper five bits
  assign w_sel     = (bus.PORT_ID[7:3] == BASE[7:3]);
  assign w_ofs     = bus.PORT_ID[2:0];
  assign w_ctrl_wr = bus.WRITE_STROBE & w_sel & (w_ofs == OFS_CONTROL);
  assign w_thr_wr  = bus.WRITE_STROBE & w_sel & (w_ofs == OFS_THRESH);
  assign w_flush   = w_ctrl_wr & bus.OUT_PORT[CTRL_FLUSH_BIT];
  assign w_clr_ovf = w_ctrl_wr & bus.OUT_PORT[CTRL_CLR_OVF_BIT];

  assign w_push_req = bus.SAMPLE_VALID & r_enable;
  assign w_pop_req  = bus.READ_STROBE & w_sel & (w_ofs == OFS_DATA);
  // Full implies non-empty, so a pop request always frees a slot here; flush drops silently
  assign w_ovf_evt  = w_push_req & w_full & ~w_pop_req & ~w_flush;

  assign w_sample = {bus.SAMPLE_RW, bus.SAMPLE_ADDR, bus.SAMPLE_DATA};

  capture_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (CLK),
    .rst_n   (RESET_N),
    .i_push  (w_push_req),
    .i_pop   (w_pop_req),
    .i_flush (w_flush),
    .i_dat   (w_sample),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_status = {r_ovf, w_full, w_empty, 5'(w_count)};

  always_comb begin
    w_rd_dat = 8'h00;
    if (w_sel) begin
      case (w_ofs)
        OFS_STATUS:  w_rd_dat = w_status;
        OFS_ADDR_LO: if (!w_empty) w_rd_dat = w_head.addr[7:0];
        OFS_ADDR_HI: if (!w_empty) w_rd_dat = w_head.addr[15:8];
        OFS_DATA:    if (!w_empty) w_rd_dat = w_head.data;
        OFS_FLAGS:   if (!w_empty) w_rd_dat = {7'b0, w_head.rw};
        OFS_THRESH:  w_rd_dat = r_thresh;
        default:     w_rd_dat = 8'h00;
      endcase
    end
  end

  // THRESH = 0 disables the fill-level source; overflow still requests
  assign w_irq_cond = r_irq_en & (((r_thresh != 8'h00) & (8'(w_count) >= r_thresh)) | r_ovf);
  assign w_irq_clr  = bus.INTERRUPT_ACK | (w_ctrl_wr & ~bus.OUT_PORT[CTRL_IRQ_EN_BIT]);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_in_port     <= 8'h00;
      r_enable      <= 1'b0;
      r_irq_en      <= 1'b0;
      r_thresh      <= 8'h00;
      r_ovf         <= 1'b0;
      r_irq_cond_q  <= 1'b0;
      r_irq_pending <= 1'b0;
    end else begin
      r_in_port    <= w_rd_dat;
      r_irq_cond_q <= w_irq_cond;
      if (w_ctrl_wr) begin
        r_enable <= bus.OUT_PORT[CTRL_EN_BIT];
        r_irq_en <= bus.OUT_PORT[CTRL_IRQ_EN_BIT];
      end
      if (w_thr_wr) r_thresh <= bus.OUT_PORT;
      // A fresh overflow in the clearing cycle is kept rather than lost
      r_ovf <= (r_ovf & ~w_clr_ovf) | w_ovf_evt;
      // Edge-triggered request; an explicit clear wins over a same-cycle rise
      if (w_irq_clr)                        r_irq_pending <= 1'b0;
      else if (w_irq_cond && !r_irq_cond_q) r_irq_pending <= 1'b1;
    end
  end

  assign bus.IN_PORT   = r_in_port;
  assign bus.INTERRUPT = r_irq_pending;
endmodule

// File: tb/tb_capture_fifo_port.sv
// Purpose: directed self-checking bench for capture_fifo_port (DEPTH_LOG2 = 4, BASE = 8'h00).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: n/a.
module tb_capture_fifo_port;
  logic CLK = 1'b0;
  logic RESET_N;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [7:0] v;

  always #5 CLK = ~CLK;

  capture_fifo_port_if bus();

  capture_fifo_port #(.DEPTH_LOG2(4), .BASE(8'h00)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  // Skip cycle with PORT_ID held, then the READ_STROBE cycle; value taken during the strobe
  task automatic rd(input logic [2:0] ofs, output logic [7:0] val);
    @(negedge CLK);
    bus.PORT_ID     = {5'b0, ofs};
    bus.READ_STROBE = 1'b0;
    @(negedge CLK);
    bus.READ_STROBE = 1'b1;
    val = bus.IN_PORT;
    @(negedge CLK);
    bus.READ_STROBE = 1'b0;
  endtask

  task automatic wr(input logic [2:0] ofs, input logic [7:0] dat);
    @(negedge CLK);
    bus.PORT_ID      = {5'b0, ofs};
    bus.OUT_PORT     = dat;
    bus.WRITE_STROBE = 1'b1;
    @(negedge CLK);
    bus.WRITE_STROBE = 1'b0;
  endtask

  task automatic push(input logic [15:0] a, input logic [7:0] d, input logic rw);
    @(negedge CLK);
    bus.SAMPLE_ADDR  = a;
    bus.SAMPLE_DATA  = d;
    bus.SAMPLE_RW    = rw;
    bus.SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    bus.SAMPLE_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    RESET_N           = 1'b0;
    bus.SAMPLE_VALID  = 1'b0;
    bus.SAMPLE_ADDR   = 16'h0000;
    bus.SAMPLE_DATA   = 8'h00;
    bus.SAMPLE_RW     = 1'b0;
    bus.PORT_ID       = 8'h00;
    bus.OUT_PORT      = 8'h00;
    bus.READ_STROBE   = 1'b0;
    bus.WRITE_STROBE  = 1'b0;
    bus.INTERRUPT_ACK = 1'b0;

    // Reset state
    idle(3);
    check("rst_in_port", bus.IN_PORT, 8'h00);
    check("rst_irq", {7'b0, bus.INTERRUPT}, 8'h00);
    RESET_N = 1'b1;
    rd(3'd0, v); check("rst_status", v, 8'h20);

    // Three samples, read back field by field
    wr(3'd0, 8'h01);
    push(16'h1234, 8'hAA, 1'b1);
    push(16'h5678, 8'hBB, 1'b0);
    push(16'h9ABC, 8'hCC, 1'b1);
    rd(3'd4, v); check("s0_flags", v, 8'h01);
    rd(3'd1, v); check("s0_lo",    v, 8'h34);
    rd(3'd2, v); check("s0_hi",    v, 8'h12);
    rd(3'd3, v); check("s0_data",  v, 8'hAA);
    rd(3'd4, v); check("s1_flags", v, 8'h00);
    rd(3'd1, v); check("s1_lo",    v, 8'h78);
    rd(3'd2, v); check("s1_hi",    v, 8'h56);
    rd(3'd3, v); check("s1_data",  v, 8'hBB);
    rd(3'd4, v); check("s2_flags", v, 8'h01);
    rd(3'd1, v); check("s2_lo",    v, 8'hBC);
    rd(3'd2, v); check("s2_hi",    v, 8'h9A);
    rd(3'd3, v); check("s2_data",  v, 8'hCC);
    rd(3'd0, v); check("drained_status", v, 8'h20);
    rd(3'd3, v); check("empty_data", v, 8'h00);

    // Overflow: 17 pushes into 16 entries
    for (int i = 0; i < 17; i++) push(16'(i), 8'(i), 1'b0);
    rd(3'd0, v); check("ovf_status", v, 8'hD0);
    wr(3'd0, 8'h05);
    rd(3'd0, v); check("ovf_cleared", v, 8'h50);

    // Push and pop in the same cycle while full
    @(negedge CLK);
    bus.PORT_ID     = 8'h03;
    bus.READ_STROBE = 1'b0;
    @(negedge CLK);
    bus.READ_STROBE  = 1'b1;
    bus.SAMPLE_ADDR  = 16'hDEAD;
    bus.SAMPLE_DATA  = 8'h5A;
    bus.SAMPLE_RW    = 1'b1;
    bus.SAMPLE_VALID = 1'b1;
    v = bus.IN_PORT;
    @(negedge CLK);
    bus.READ_STROBE  = 1'b0;
    bus.SAMPLE_VALID = 1'b0;
    check("pp_head", v, 8'h00);
    rd(3'd0, v); check("pp_status", v, 8'h50);
    for (int i = 1; i < 16; i++) begin
      rd(3'd3, v); check("pp_drain", v, 8'(i));
    end
    rd(3'd4, v); check("tail_flags", v, 8'h01);
    rd(3'd1, v); check("tail_lo",    v, 8'hAD);
    rd(3'd2, v); check("tail_hi",    v, 8'hDE);
    rd(3'd3, v); check("tail_data",  v, 8'h5A);
    rd(3'd0, v); check("tail_status", v, 8'h20);

    // Threshold interrupt
    wr(3'd5, 8'h04);
    rd(3'd5, v); check("thresh_rb", v, 8'h04);
    wr(3'd0, 8'h09);
    for (int i = 0; i < 3; i++) push(16'h0100, 8'(i), 1'b0);
    check("irq_below", {7'b0, bus.INTERRUPT}, 8'h00);
    push(16'h0100, 8'h03, 1'b0);
    check("irq_lat0", {7'b0, bus.INTERRUPT}, 8'h00);
    @(negedge CLK);
    check("irq_lat1", {7'b0, bus.INTERRUPT}, 8'h01);
    bus.INTERRUPT_ACK = 1'b1;
    @(negedge CLK);
    bus.INTERRUPT_ACK = 1'b0;
    check("irq_ack", {7'b0, bus.INTERRUPT}, 8'h00);
    push(16'h0100, 8'h04, 1'b0);
    idle(3);
    check("irq_no_rearm", {7'b0, bus.INTERRUPT}, 8'h00);

    // Flush with a same-cycle push
    @(negedge CLK);
    bus.PORT_ID      = 8'h00;
    bus.OUT_PORT     = 8'h03;
    bus.WRITE_STROBE = 1'b1;
    bus.SAMPLE_VALID = 1'b1;
    @(negedge CLK);
    bus.WRITE_STROBE = 1'b0;
    bus.SAMPLE_VALID = 1'b0;
    rd(3'd0, v); check("flush_status", v, 8'h20);

    // Asynchronous reset mid-fill with the interrupt raised
    wr(3'd0, 8'h09);
    for (int i = 0; i < 4; i++) push(16'h0200, 8'(i), 1'b0);
    idle(1);
    check("pre_rst_irq", {7'b0, bus.INTERRUPT}, 8'h01);
    check("pre_rst_in_port", bus.IN_PORT, 8'h04);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_irq", {7'b0, bus.INTERRUPT}, 8'h00);
    check("arst_in_port", bus.IN_PORT, 8'h00);
    @(negedge CLK);
    RESET_N = 1'b1;
    rd(3'd0, v); check("post_rst_status", v, 8'h20);
    rd(3'd5, v); check("post_rst_thresh", v, 8'h00);
    push(16'h0300, 8'h77, 1'b1);
    rd(3'd0, v); check("disabled_push", v, 8'h20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
